// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the up/down counter and the CDC FIFO pointers.
// The helpers work on the maximum width. Callers zero-extend narrower values and
// keep the low N bits of the result; zero upper bits leave both conversions exact.
package gray_pkg;

  localparam int GRAY_MAX_N = 32;

  // Binary to Gray: each Gray bit marks a change between adjacent binary bits.
  function automatic logic [GRAY_MAX_N-1:0] bin2gray(input logic [GRAY_MAX_N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: bin[i] is the XOR of gray[MAX-1:i], computed top-down.
  function automatic logic [GRAY_MAX_N-1:0] gray2bin(input logic [GRAY_MAX_N-1:0] g);
    logic [GRAY_MAX_N-1:0] b;
    b[GRAY_MAX_N-1] = g[GRAY_MAX_N-1];
    for (int i = GRAY_MAX_N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Parametrised N-bit combinational Gray-to-binary converter.
// Each output bit is the XOR reduction of the Gray bits at and above it.
module gray_to_bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // One XOR reduction per output bit; the synthesis tool shares the common terms.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[N-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// N-bit up/down Gray-code counter with synchronous load and reset.
// It either wraps modulo 2^N or saturates at the range ends, and flags both
// boundary events with a registered one-cycle pulse on wrap.
// Optional: define GRAY_UPDOWN_COUNTER_BIN_OUT_EN to expose the registered binary
// count on q_bin.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int          N           = 4,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  input  logic         up,
  output logic [N-1:0] q,
  output logic         wrap,
  output logic         at_end
`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
  ,
  output logic [N-1:0] q_bin
`endif
);

  // Convert the low N bits through the shared full-width helper.
  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    logic [GRAY_MAX_N-1:0] g;
    g = bin2gray(GRAY_MAX_N'(b));
    return g[N-1:0];
  endfunction

  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] RST_BIN  = N'(RESET_VALUE);
  localparam logic [N-1:0] RST_GRAY = to_gray(RST_BIN);

  logic [N-1:0] b_q, b_d;
  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] load_bin;
  logic [N-1:0] b_step;

  // Decode the Gray load value once so a load sets both registers together.
  gray_to_bin #(.N(N)) u_load_dec (
    .gray_i (load_value),
    .bin_o  (load_bin)
  );

  // The next step lies beyond the range end in the current direction.
  assign at_end = up ? (b_q == {N{1'b1}}) : (b_q == {N{1'b0}});

  // Modulo step. The carry or borrow is dropped here; at_end already covers it.
  assign b_step = up ? (b_q + ONE) : (b_q - ONE);

  // Next-state selection in priority order: load, count, hold. Reset is applied in the flop.
  always_comb begin
    b_d    = b_q;
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      b_d = load_bin;
      q_d = load_value;
    end else if (enable) begin
      if (at_end) begin
        wrap_d = 1'b1;
        if (!SATURATE) begin
          b_d = b_step;
        end
      end else begin
        b_d = b_step;
      end
      q_d = to_gray(b_d);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= RST_BIN;
      q_q    <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
  assign q_bin = b_q;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed and random checks for gray_updown_counter at N=4.
// One wrapping instance and one saturating instance share the same stimulus.
module tb_gray_updown_counter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, load, enable, up;
  logic [N-1:0] load_value;
  logic [N-1:0] q_w, q_s;
  logic         wrap_w, wrap_s, at_end_w, at_end_s;
`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
  logic [N-1:0] qb_w, qb_s;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.N(N), .SATURATE(1'b0), .RESET_VALUE(0)) u_wrap (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .enable(enable), .up(up), .q(q_w), .wrap(wrap_w), .at_end(at_end_w)
`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
    , .q_bin(qb_w)
`endif
  );

  gray_updown_counter #(.N(N), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .enable(enable), .up(up), .q(q_s), .wrap(wrap_s), .at_end(at_end_s)
`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
    , .q_bin(qb_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic l, input logic [N-1:0] lv,
                       input logic e, input logic u);
    rst = r; load = l; load_value = lv; enable = e; up = u;
  endtask

  // Check q and wrap on both instances.
  task automatic exp2(input string tag, input logic [N-1:0] qw, input logic ww,
                      input logic [N-1:0] qs, input logic ws);
    chk({tag, ".q_w"},    32'(q_w),    32'(qw));
    chk({tag, ".wrap_w"}, 32'(wrap_w), 32'(ww));
    chk({tag, ".q_s"},    32'(q_s),    32'(qs));
    chk({tag, ".wrap_s"}, 32'(wrap_s), 32'(ws));
  endtask

  logic [N-1:0] up_seq [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};

  initial begin
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Reset for two cycles. at_end is valid during reset.
    for (int i = 0; i < 2; i++) begin
      tick();
      exp2("reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
      chk("reset.at_end_up", 32'(at_end_w), 32'd0);
    end
    up = 1'b0; #1;
    chk("reset.at_end_dn", 32'(at_end_w), 32'd1);
`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
    chk("reset.q_bin", 32'(qb_w), 32'd0);
`endif

    // Count up five steps.
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp2($sformatf("upcnt%0d", i), up_seq[i], 1'b0, up_seq[i], 1'b0);
    end
`ifdef GRAY_UPDOWN_COUNTER_BIN_OUT_EN
    chk("upcnt.q_bin", 32'(qb_w), 32'd5);
`endif

    // Load gray 1000 (bin 15). A load clears wrap and sets at_end when counting up.
    drive(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1);
    tick();
    exp2("load15", 4'b1000, 1'b0, 4'b1000, 1'b0);
    chk("load15.at_end_s", 32'(at_end_s), 32'd1);

    // Step up from 15. The wrapping instance goes to 0; the saturating instance is blocked.
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    exp2("upend", 4'b0000, 1'b1, 4'b1000, 1'b1);
    // Step down. The wrapping instance goes 0 -> 15; the saturating instance goes 15 -> 14.
    up = 1'b0;
    tick();
    exp2("dnwrap", 4'b1000, 1'b1, 4'b1001, 1'b0);

    // Repeat blocked steps on the saturating instance.
    drive(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    tick(); exp2("sat1", 4'b0000, 1'b1, 4'b1000, 1'b1);
    tick(); exp2("sat2", 4'b0001, 1'b0, 4'b1000, 1'b1);
    tick(); exp2("sat3", 4'b0011, 1'b0, 4'b1000, 1'b1);
    chk("sat3.at_end_s", 32'(at_end_s), 32'd1);

    // Step down from 0.
    drive(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    exp2("dnend", 4'b1000, 1'b1, 4'b0000, 1'b1);

    // Reset overrides load and enable.
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1);
    tick();
    exp2("prio_rst", 4'b0000, 1'b0, 4'b0000, 1'b0);
    // Load has priority over enable.
    drive(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1);
    tick();
    exp2("prio_load", 4'b0110, 1'b0, 4'b0110, 1'b0);

    // Toggle up while enable is low; the count holds.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'(i));
      tick();
      exp2($sformatf("hold%0d", i), 4'b0110, 1'b0, 4'b0110, 1'b0);
    end
    // Count down from 4 to 3 with no dead cycle.
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    exp2("dn_after_hold", 4'b0010, 1'b0, 4'b0010, 1'b0);

    // Reset in the middle of a count.
    up = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    exp2("mid_rst", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // On any edge without reset or load, q changes by at most one bit.
    begin
      logic [N-1:0] pw, ps;
      logic r, l;
      pw = q_w; ps = q_s;
      for (int i = 0; i < 10000; i++) begin
        r = ($urandom_range(0, 99) == 0);
        l = ($urandom_range(0, 15) == 0);
        drive(r, l, N'($urandom), 1'($urandom), 1'($urandom));
        tick();
        if (!r && !l) begin
          chk("onebit_w", 32'($countones(q_w ^ pw) <= 1), 32'd1);
          chk("onebit_s", 32'($countones(q_s ^ ps) <= 1), 32'd1);
        end
        pw = q_w; ps = q_s;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
